// File: rtl/gfx_pkg.sv
// Shared definitions for the graphics command path: default geometry, command
// opcodes, the pixel-writer FSM encoding and small arithmetic helpers.
package gfx_pkg;

  localparam int unsigned COORD_W       = 8;
  localparam int unsigned COLOR_W       = 8;
  localparam int unsigned FB_WIDTH      = 256;
  localparam int unsigned FB_HEIGHT     = 192;
  localparam int unsigned ADDR_W        = 16;
  localparam int unsigned PW_FIFO_DEPTH = 4;

  // Command opcodes of the upstream command control unit
  localparam logic [7:0] CMD_POINT = 8'd80;
  localparam logic [7:0] CMD_LINE  = 8'd76;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } pw_state_e;

  // Saturating increment for 8-bit event counters
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pw_fifo.sv
// Synchronous FIFO holding plotted pixels ahead of the framebuffer writer.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   push_i       write wdata_i (ignored when full)
//   wdata_i      entry to store
//   pop_i        drop the head entry (ignored when empty)
//   rdata_o      current head entry (valid when !empty_o)
//   empty_o      no entries held
//   full_o       DEPTH entries held
module pw_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty
  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[PTR_W-1:0]];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Storage and pointer update; push and pop may coincide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
        wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/pixel_writer.sv
// Pixel writer: buffers plotted pixels, clips them to the framebuffer, forms
// linear addresses and issues framebuffer writes over a req/ack port. Also
// fills the whole screen with one colour on request.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   plot_valid/plot_ready             pixel handshake (ready is combinational)
//   plot_x, plot_y, plot_color        offered pixel
//   clr_start, clr_color              full-screen clear request and fill colour
//   mem_req/mem_addr/mem_data/mem_ack framebuffer write port
//   busy                              work queued, outstanding or pending
//   clip_count                        saturating count of clipped pixels
module pixel_writer #(
  parameter int unsigned COORD_W    = gfx_pkg::COORD_W,
  parameter int unsigned COLOR_W    = gfx_pkg::COLOR_W,
  parameter int unsigned FB_WIDTH   = gfx_pkg::FB_WIDTH,
  parameter int unsigned FB_HEIGHT  = gfx_pkg::FB_HEIGHT,
  parameter int unsigned ADDR_W     = gfx_pkg::ADDR_W,
  parameter int unsigned FIFO_DEPTH = gfx_pkg::PW_FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               plot_valid,
  output logic               plot_ready,
  input  logic [COORD_W-1:0] plot_x,
  input  logic [COORD_W-1:0] plot_y,
  input  logic [COLOR_W-1:0] plot_color,
  input  logic               clr_start,
  input  logic [COLOR_W-1:0] clr_color,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_data,
  input  logic               mem_ack,
  output logic               busy,
  output logic [7:0]         clip_count
);

  import gfx_pkg::*;

  localparam int unsigned ENT_W     = 2*COORD_W + COLOR_W;
  localparam int unsigned FB_PIXELS = FB_WIDTH * FB_HEIGHT;
  localparam int unsigned XB        = $clog2(FB_WIDTH);
  localparam bit          W_POW2    = (FB_WIDTH == (32'd1 << XB));

  // Registered state and outputs
  pw_state_e          state_q, state_d;
  logic               mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [COLOR_W-1:0] mem_data_q, mem_data_d;
  logic               clr_pend_q, clr_pend_d;
  logic               clr_act_q, clr_act_d;
  logic [COLOR_W-1:0] clr_color_q, clr_color_d;
  logic [7:0]         clip_cnt_q, clip_cnt_d;

  // FIFO interface
  logic               fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [ENT_W-1:0]   fifo_wdata, fifo_head;
  logic [COORD_W-1:0] head_x, head_y;
  logic [COLOR_W-1:0] head_c;
  logic               head_in_range;
  logic [ADDR_W-1:0]  head_addr;

  assign plot_ready = !fifo_full && !clr_pend_q && !clr_act_q;
  assign fifo_push  = plot_valid && plot_ready;
  assign fifo_wdata = {plot_x, plot_y, plot_color};

  pw_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign head_x = fifo_head[ENT_W-1 -: COORD_W];
  assign head_y = fifo_head[COLOR_W +: COORD_W];
  assign head_c = fifo_head[COLOR_W-1:0];

  // Clip check on the FIFO head
  assign head_in_range = (32'(head_x) < FB_WIDTH) && (32'(head_y) < FB_HEIGHT);

  // Linear address of the head; a power-of-two row width reduces to a concatenation
  always_comb begin
    if (W_POW2) begin
      head_addr = ADDR_W'((32'(head_y) << XB) | 32'(head_x));
    end else begin
      head_addr = ADDR_W'(32'(head_y) * FB_WIDTH + 32'(head_x));
    end
  end

  // Next-state logic: FSM, clear request capture, clip counter
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    clr_pend_d  = clr_pend_q;
    clr_act_d   = clr_act_q;
    clr_color_d = clr_color_q;
    clip_cnt_d  = clip_cnt_q;
    fifo_pop    = 1'b0;

    // A clear request already pending or running swallows further requests
    if (clr_start && !clr_pend_q && !clr_act_q) begin
      clr_pend_d  = 1'b1;
      clr_color_d = clr_color;
    end

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head_in_range) begin
            mem_req_d  = 1'b1;
            mem_addr_d = head_addr;
            mem_data_d = head_c;
            state_d    = ST_WRITE;
          end else begin
            clip_cnt_d = sat_inc8(clip_cnt_q);
          end
        end else if (clr_pend_q) begin
          clr_pend_d = 1'b0;
          clr_act_d  = 1'b1;
          mem_req_d  = 1'b1;
          mem_addr_d = '0;
          mem_data_d = clr_color_q;
          state_d    = ST_CLEAR;
        end
      end

      ST_WRITE: begin
        if (mem_ack) begin
          // Chain straight into the next in-range pixel; clipping waits for IDLE
          if (!fifo_empty && head_in_range) begin
            fifo_pop   = 1'b1;
            mem_addr_d = head_addr;
            mem_data_d = head_c;
          end else begin
            mem_req_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end
      end

      ST_CLEAR: begin
        if (mem_ack) begin
          if (mem_addr_q == ADDR_W'(FB_PIXELS - 1)) begin
            mem_req_d = 1'b0;
            clr_act_d = 1'b0;
            state_d   = ST_IDLE;
          end else begin
            mem_addr_d = mem_addr_q + ADDR_W'(1);
          end
        end
      end

      default: begin
        mem_req_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      clr_pend_q  <= 1'b0;
      clr_act_q   <= 1'b0;
      clr_color_q <= '0;
      clip_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      clr_pend_q  <= clr_pend_d;
      clr_act_q   <= clr_act_d;
      clr_color_q <= clr_color_d;
      clip_cnt_q  <= clip_cnt_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign clip_count = clip_cnt_q;
  assign busy       = !fifo_empty || mem_req_q || clr_pend_q || clr_act_q;

endmodule
